debounce_en: RTL and testbench

//  Input conditioning stage placed directly upstream of the lab D flip-flop.

---
 rtl/debounce_en.sv | 146 ++++++++++++++
 tb/tb_debounce_en.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/debounce_en.sv
// ============================================================================
// Module   : debounce_en
// Purpose  : Synchronises and debounces a raw level. The outputs are the clean
//            level q, a one-cycle enable pulse en, and rise/fall edge strobes.
// Options  : DB_TOGGLE_EN - q toggles on each accepted rising change
//            (push-on/push-off mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_en #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic en,
  output logic rise,
  output logic fall
);

  localparam logic [1:0] c_low_stable  = 2'd0;
  localparam logic [1:0] c_low_check   = 2'd1;
  localparam logic [1:0] c_high_stable = 2'd2;
  localparam logic [1:0] c_high_check  = 2'd3;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_acc_rise;
  logic                   w_acc_fall;
  logic                   w_pulse;
  logic                   w_q_nxt;
  logic                   r_q;
  logic                   r_en;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The state tracks the debounced input level, which can differ from q in
  // toggle mode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_rise  = 1'b0;
    w_acc_fall  = 1'b0;
    case (r_state)
      c_low_stable: begin
        if (w_s) begin
          w_state_nxt = c_low_check;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      c_low_check: begin
        if (!w_s) begin
          w_state_nxt = c_low_stable;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_high_stable;
          w_cnt_nxt   = '0;
          w_acc_rise  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      c_high_stable: begin
        if (!w_s) begin
          w_state_nxt = c_high_check;
          w_cnt_nxt   = c_cnt_one;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      c_high_check: begin
        if (w_s) begin
          w_state_nxt = c_high_stable;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_low_stable;
          w_cnt_nxt   = '0;
          w_acc_fall  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = c_low_stable;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DB_TOGGLE_EN
  assign w_pulse = w_acc_rise;
  assign w_q_nxt = w_acc_rise ? ~r_q : r_q;
`else
  assign w_pulse = w_acc_rise | w_acc_fall;
  assign w_q_nxt = w_acc_rise ? 1'b1 : (w_acc_fall ? 1'b0 : r_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_low_stable;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_en    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_en    <= w_pulse;
      r_rise  <= w_pulse & w_q_nxt;
      r_fall  <= w_pulse & ~w_q_nxt;
    end
  end

  assign q    = r_q;
  assign en   = r_en;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

`default_nettype wire

// File: tb/tb_debounce_en.sv
// ============================================================================
// Module   : tb_debounce_en
// Purpose  : Randomised and directed bench for debounce_en with a scoreboard
//            that is fed by a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_en;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 3;

  logic clk;
  logic rst;
  logic din;
  logic q;
  logic en;
  logic rise;
  logic fall;

  int vectors;
  int miscompares;
  int cycle;

  logic [3:0] sb[$];

  debounce_en #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .q   (q),
    .en  (en),
    .rise(rise),
    .fall(fall)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Reference model: s is din delayed by SYNC_STAGES edges. The debounced
  // level flips once s has differed from it on STABLE_CYCLES consecutive edges.
  bit m_hist[SYNC_STAGES];
  bit m_lvl;
  bit m_tq;
  int m_run;

  always @(posedge clk) begin
    bit s;
    bit flip;
    bit pulse;
    bit mq;
    cycle = cycle + 1;
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_lvl = 1'b0;
      m_tq  = 1'b0;
      m_run = 0;
      sb.push_back(4'b0000);
    end else begin
      s = m_hist[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = din;
      flip = 1'b0;
      if (s != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == STABLE_CYCLES) begin
          m_lvl = s;
          m_run = 0;
          flip  = 1'b1;
        end
      end else begin
        m_run = 0;
      end
`ifdef DB_TOGGLE_EN
      pulse = flip && m_lvl;
      if (pulse) m_tq = ~m_tq;
      mq = m_tq;
`else
      pulse = flip;
      mq = m_lvl;
`endif
      sb.push_back({mq, pulse, pulse & mq, pulse & ~mq});
    end
  end

  // Monitor: samples 10 ns after each rising edge, before stimulus moves.
  initial begin
    logic [3:0] exp_v;
    logic [3:0] got_v;
    forever begin
      @(posedge clk);
      #10;
      got_v = {q, en, rise, fall};
      vectors = vectors + 1;
      if (sb.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL scoreboard_empty cycle %0d: got q/en/rise/fall=%b, no expected entry",
                 cycle, got_v);
      end else begin
        exp_v = sb.pop_front();
        if (got_v !== exp_v) begin
          miscompares = miscompares + 1;
          $display("FAIL outputs cycle %0d: got q/en/rise/fall=%b required %b",
                   cycle, got_v, exp_v);
        end
      end
    end
  end

  task automatic drive(input logic d, input logic r, input int n);
    repeat (n) begin
      @(posedge clk);
      #30;
      din = d;
      rst = r;
    end
  endtask

  initial begin
    int len;
    logic d;
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    rst         = 1'b0;
    din         = 1'b1;

    // Reset with din high, then release: treated as a 0->1 change.
    drive(1'b1, 1'b0, 5);
    drive(1'b1, 1'b1, 12);
    // Clean steps.
    drive(1'b0, 1'b1, 12);
    drive(1'b1, 1'b1, 12);
    drive(1'b0, 1'b1, 12);
    // Bounce then hold high.
    drive(1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 2);
    drive(1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 2);
    drive(1'b1, 1'b1, 12);
    drive(1'b0, 1'b1, 12);
    // Glitch shorter than the stability window.
    drive(1'b1, 1'b1, 3);
    drive(1'b0, 1'b1, 10);
    // Reset in the middle of a check window.
    drive(1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 12);

    for (int seg = 0; seg < 400; seg++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) len = $urandom_range(8, 12);
      else len = $urandom_range(1, 7);
      if ($urandom_range(0, 39) == 0) drive(d, 1'b0, $urandom_range(1, 2));
      drive(d, 1'b1, len);
    end
    drive(1'b0, 1'b1, 12);

    @(posedge clk);
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
